result_bcd_converter: RTL and testbench



---
 rtl/result_bcd_converter_if.sv | 23 ++
 rtl/result_bcd_converter.sv | 105 ++++++++++
 tb/tb_result_bcd_converter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/result_bcd_converter_if.sv
// Handshake and result bus between the ALU-side requester and the BCD converter.
interface result_bcd_converter_if #(
    parameter int BIN_WIDTH = 21,
    parameter int DIGITS    = 7
);
    logic                  start;
    logic [BIN_WIDTH-1:0]  bin_in;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  neg;
    logic                  overflow;
    logic                  busy;
    logic                  done;

    modport master (
        output start, bin_in,
        input  bcd_out, neg, overflow, busy, done
    );

    modport slave (
        input  start, bin_in,
        output bcd_out, neg, overflow, busy, done
    );
endinterface

// File: rtl/result_bcd_converter.sv
// Sequential signed-binary to packed-BCD converter (shift-add-3, one bit per clock).
// Critical path is a single parallel digit adjust followed by a one-bit shift.
module result_bcd_converter #(
    parameter int BIN_WIDTH = 21,
    parameter int DIGITS    = 7
) (
    input  logic                    clock,
    input  logic                    reset,
    result_bcd_converter_if.slave   bus
);
    localparam int CW = $clog2(BIN_WIDTH + 1);
    localparam int SW = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e                state_q, state_d;
    logic [SW-1:0]         scr_q, scr_d;
    logic [SW-1:0]         adj;
    logic [BIN_WIDTH-1:0]  mag_q, mag_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  sign_q, sign_d;
    logic                  sticky_q, sticky_d;
    logic [SW-1:0]         bcd_q, bcd_d;
    logic                  neg_q, neg_d;
    logic                  ovf_q, ovf_d;
    logic                  done_q, done_d;

    // Every digit is corrected in parallel before the shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        assign adj[4*g +: 4] = (scr_q[4*g +: 4] >= 4'd5) ? scr_q[4*g +: 4] + 4'd3
                                                          : scr_q[4*g +: 4];
    end

    always_comb begin
        state_d  = state_q;
        scr_d    = scr_q;
        mag_d    = mag_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        sticky_d = sticky_q;
        bcd_d    = bcd_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Negating the most negative value wraps to 2^(W-1), which is the correct magnitude.
                    sign_d   = bus.bin_in[BIN_WIDTH-1];
                    mag_d    = bus.bin_in[BIN_WIDTH-1] ? (~bus.bin_in + BIN_WIDTH'(1)) : bus.bin_in;
                    scr_d    = '0;
                    sticky_d = 1'b0;
                    cnt_d    = CW'(BIN_WIDTH);
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                {scr_d, mag_d} = {adj[SW-2:0], mag_q, 1'b0};
                sticky_d       = sticky_q | adj[SW-1];
                cnt_d          = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = DONE;
            end
            DONE: begin
                bcd_d   = sticky_q ? {DIGITS{4'h9}} : scr_q;
                neg_d   = sign_q;
                ovf_d   = sticky_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            scr_q    <= '0;
            mag_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            sticky_q <= 1'b0;
            bcd_q    <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            scr_q    <= scr_d;
            mag_q    <= mag_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            sticky_q <= sticky_d;
            bcd_q    <= bcd_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign bus.bcd_out  = bcd_q;
    assign bus.neg      = neg_q;
    assign bus.overflow = ovf_q;
    assign bus.done     = done_q;
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_result_bcd_converter.sv
// Directed plus randomized checks of the BCD converter against an arithmetic reference.
module tb_result_bcd_converter;
    logic clock = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    logic [27:0] p_bcd;
    logic        p_neg, p_ovf;

    always #5 clock = ~clock;

    result_bcd_converter_if #(.BIN_WIDTH(21), .DIGITS(7)) if0 ();
    result_bcd_converter_if #(.BIN_WIDTH(21), .DIGITS(4)) if4 ();

    result_bcd_converter #(.BIN_WIDTH(21), .DIGITS(7)) dut0 (
        .clock(clock), .reset(reset), .bus(if0.slave)
    );
    result_bcd_converter #(.BIN_WIDTH(21), .DIGITS(4)) dut4 (
        .clock(clock), .reset(reset), .bus(if4.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal digits of |v| by repeated division; all nines when it does not fit.
    function automatic void refm(input longint v, input int d,
                                 output logic [63:0] bcd, output logic n, output logic o);
        longint mag, lim, t;
        mag = (v < 0) ? -v : v;
        lim = 1;
        for (int i = 0; i < d; i++) lim = lim * 10;
        n = (v < 0);
        o = (mag >= lim);
        bcd = '0;
        t = mag;
        for (int i = 0; i < d; i++) begin
            bcd[4*i +: 4] = o ? 4'h9 : 4'(t % 10);
            t = t / 10;
        end
    endfunction

    task automatic run0(input longint v);
        logic [63:0] eb; logic en, eo;
        int n, bad_busy, unstable;
        refm(v, 7, eb, en, eo);
        if0.bin_in = v[20:0];
        if0.start  = 1'b1;
        @(negedge clock);
        if0.start  = 1'b0;
        if0.bin_in = 21'($urandom);
        n = 0; bad_busy = 0; unstable = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            if (if0.done) begin n = k; break; end
            if (if0.busy !== 1'b1) bad_busy++;
            if (if0.bcd_out !== p_bcd || if0.neg !== p_neg || if0.overflow !== p_ovf) unstable++;
        end
        chk("latency", 64'(n), 64'd22);
        chk("busy_during", 64'(bad_busy), 64'd0);
        chk("held_stable", 64'(unstable), 64'd0);
        chk("busy_at_done", {63'd0, if0.busy}, 64'd0);
        chk("bcd", {36'd0, if0.bcd_out}, eb);
        chk("neg", {63'd0, if0.neg}, {63'd0, en});
        chk("ovf", {63'd0, if0.overflow}, {63'd0, eo});
        p_bcd = if0.bcd_out; p_neg = if0.neg; p_ovf = if0.overflow;
        @(negedge clock);
        chk("done_one_cycle", {63'd0, if0.done}, 64'd0);
    endtask

    task automatic run4(input longint v);
        logic [63:0] eb; logic en, eo;
        int n;
        refm(v, 4, eb, en, eo);
        if4.bin_in = v[20:0];
        if4.start  = 1'b1;
        @(negedge clock);
        if4.start  = 1'b0;
        n = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            if (if4.done) begin n = k; break; end
        end
        chk("d4_latency", 64'(n), 64'd22);
        chk("d4_bcd", {48'd0, if4.bcd_out}, eb);
        chk("d4_neg", {63'd0, if4.neg}, {63'd0, en});
        chk("d4_ovf", {63'd0, if4.overflow}, {63'd0, eo});
        @(negedge clock);
    endtask

    initial begin
        int dones;
        logic [27:0] cap;
        logic [20:0] r;
        reset = 1'b1;
        if0.start = 1'b0; if0.bin_in = '0;
        if4.start = 1'b0; if4.bin_in = '0;
        repeat (3) @(negedge clock);
        chk("rst_bcd", {36'd0, if0.bcd_out}, 64'd0);
        chk("rst_neg", {63'd0, if0.neg}, 64'd0);
        chk("rst_ovf", {63'd0, if0.overflow}, 64'd0);
        chk("rst_busy", {63'd0, if0.busy}, 64'd0);
        chk("rst_done", {63'd0, if0.done}, 64'd0);
        reset = 1'b0;
        p_bcd = '0; p_neg = 1'b0; p_ovf = 1'b0;
        @(negedge clock);

        run0(0);
        run0(1234);
        run0(-5);
        run0(-1048576);
        run0(1048575);

        run4(12345);
        run4(9999);
        run4(-10000);

        // Second start while converting must be dropped.
        if0.bin_in = 21'd42; if0.start = 1'b1;
        @(negedge clock);
        if0.start = 1'b0;
        repeat (5) @(negedge clock);
        if0.bin_in = 21'd77; if0.start = 1'b1;
        @(negedge clock);
        if0.start = 1'b0;
        dones = 0; cap = '0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (if0.done) begin dones++; cap = if0.bcd_out; end
        end
        chk("ignore_start_dones", 64'(dones), 64'd1);
        chk("ignore_start_bcd", {36'd0, cap}, 64'h42);
        p_bcd = if0.bcd_out; p_neg = if0.neg; p_ovf = if0.overflow;

        // Reset in the middle of a conversion aborts it.
        run0(7);
        if0.bin_in = 21'd500; if0.start = 1'b1;
        @(negedge clock);
        if0.start = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_bcd", {36'd0, if0.bcd_out}, 64'd0);
        chk("abort_busy", {63'd0, if0.busy}, 64'd0);
        chk("abort_done", {63'd0, if0.done}, 64'd0);
        reset = 1'b0;
        dones = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (if0.done) dones++;
        end
        chk("abort_no_done", 64'(dones), 64'd0);
        p_bcd = '0; p_neg = 1'b0; p_ovf = 1'b0;
        run0(500);

        for (int i = 0; i < 20; i++) begin
            r = 21'($urandom);
            run0(longint'($signed(r)));
        end
        for (int i = 0; i < 10; i++) run4(longint'($urandom_range(0, 40000)) - 20000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
